// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the MEM stage (default priority) and a debug port.
// Define DMEM_ARB_STARVE_EN to add the starvation counter and the one-cycle FORCE slot.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_rd,
    input  logic                  pipe_wr,
    input  logic [DM_ADDRESS-1:0] pipe_addr,
    input  logic [DATA_W-1:0]     pipe_wdata,
    input  logic [2:0]            pipe_func3,
    output logic [DATA_W-1:0]     pipe_rdata,
    output logic                  pipe_stall,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);
    logic              pipe_act;
    logic              dbg_sel;
    logic              dbg_rvalid_d, dbg_rvalid_q;
    logic [DATA_W-1:0] dbg_rdata_d, dbg_rdata_q;

    assign pipe_act = pipe_rd | pipe_wr;

`ifdef DMEM_ARB_STARVE_EN
    typedef enum logic {NORM, FORCE} state_t;
    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          pipe_stall_q, pipe_stall_d;

    always_comb begin
        state_d = NORM;
        wcnt_d  = '0;
        if (state_q == NORM && dbg_valid && pipe_act) begin
            if (wcnt_q == CW'(MAX_WAIT - 1))
                state_d = FORCE;
            else
                wcnt_d = (wcnt_q == CW'(MAX_WAIT)) ? wcnt_q : wcnt_q + 1'b1;
        end
        pipe_stall_d = state_d == FORCE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NORM;
            wcnt_q       <= '0;
            pipe_stall_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            pipe_stall_q <= pipe_stall_d;
        end
    end

    // In FORCE the pipeline is frozen, so its access is dropped and replayed next cycle.
    assign dbg_sel    = (state_q == FORCE) || !pipe_act;
    assign pipe_stall = pipe_stall_q;
`else
    logic unused_cfg;

    assign unused_cfg = MAX_WAIT > 0;
    assign dbg_sel    = !pipe_act;
    assign pipe_stall = 1'b0;
`endif

    assign dbg_ready  = dbg_valid & dbg_sel;
    assign mem_rd     = dbg_sel ? dbg_ready & ~dbg_we : pipe_rd;
    assign mem_wr     = dbg_sel ? dbg_ready & dbg_we : pipe_wr;
    assign mem_addr   = dbg_sel ? dbg_addr : pipe_addr;
    assign mem_wdata  = dbg_sel ? dbg_wdata : pipe_wdata;
    assign mem_func3  = dbg_sel ? 3'b010 : pipe_func3;
    assign pipe_rdata = mem_rdata;

    always_comb begin
        dbg_rvalid_d = dbg_ready & ~dbg_we;
        dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural word memory behind it.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_rd, pipe_wr;
    logic [8:0]  pipe_addr;
    logic [31:0] pipe_wdata;
    logic [2:0]  pipe_func3;
    logic [31:0] pipe_rdata;
    logic        pipe_stall;
    logic        dbg_valid, dbg_ready, dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:127];
    int          wr30_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr[8:2]] <= mem_wdata;
            if (mem_addr == 9'h030) wr30_cnt <= wr30_cnt + 1;
        end
    end

    dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_func3(pipe_func3), .pipe_rdata(pipe_rdata),
        .pipe_stall(pipe_stall),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_rd = 0; pipe_wr = 0; pipe_addr = '0; pipe_wdata = '0; pipe_func3 = 3'b010;
        dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
        #1;
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", pipe_stall); end
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", dbg_rdata); end
        checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", dbg_ready); end
    endtask

    task automatic test_dbg_write_read();
        cyc();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 9'h010; dbg_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL dbgw_ready got %b exp 1", dbg_ready); end
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 9'h010) begin errors++; $display("FAIL dbgw_port got wr=%b addr=%h exp 1 010", mem_wr, mem_addr); end
        checks++; if (mem_func3 !== 3'b010) begin errors++; $display("FAIL dbgw_func3 got %b exp 010", mem_func3); end
        cyc();
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL dbgw_commit got %h exp deadbeef", mem[4]); end
        dbg_we = 0;
        #1;
        checks++; if (dbg_ready !== 1'b1 || mem_rd !== 1'b1) begin errors++; $display("FAIL dbgr_accept got ready=%b rd=%b exp 1 1", dbg_ready, mem_rd); end
        cyc();
        dbg_valid = 0;
        checks++; if (dbg_rvalid !== 1'b1) begin errors++; $display("FAIL dbgr_rvalid got %b exp 1", dbg_rvalid); end
        checks++; if (dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dbgr_rdata got %h exp deadbeef", dbg_rdata); end
        cyc();
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL dbgr_pulse got %b exp 0", dbg_rvalid); end
    endtask

    task automatic test_priority();
        pipe_wr = 1; pipe_addr = 9'h020; pipe_wdata = 32'd5; pipe_func3 = 3'b010;
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h020;
        #1;
        checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got %b exp 0", dbg_ready); end
        checks++; if (mem_wr !== 1'b1 || mem_addr !== 9'h020 || mem_wdata !== 32'd5) begin errors++; $display("FAIL prio_port got wr=%b addr=%h wd=%h exp 1 020 5", mem_wr, mem_addr, mem_wdata); end
        cyc();
        pipe_wr = 0;
        #1;
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL prio_accept got %b exp 1", dbg_ready); end
        cyc();
        dbg_valid = 0;
        checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'd5) begin errors++; $display("FAIL prio_rdata got v=%b d=%h exp 1 5", dbg_rvalid, dbg_rdata); end
        pipe_rd = 1; pipe_addr = 9'h010; pipe_func3 = 3'b100;
        #1;
        checks++; if (pipe_rdata !== 32'hDEADBEEF || mem_func3 !== 3'b100) begin errors++; $display("FAIL pipe_pass got d=%h f=%b exp deadbeef 100", pipe_rdata, mem_func3); end
        cyc();
        idle();
    endtask

`ifdef DMEM_ARB_STARVE_EN
    task automatic test_force();
        logic [8:0] op_addr [0:5];
        logic       op_wr   [0:5];
        int idx = 0;
        int first_ready = 0;
        logic prev_stall = 0;
        for (int i = 0; i < 6; i++) begin op_addr[i] = 9'h000; op_wr[i] = 0; end
        op_addr[4] = 9'h030; op_wr[4] = 1;
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h010;
        for (int c = 1; c <= 7; c++) begin
            pipe_rd = ~op_wr[idx]; pipe_wr = op_wr[idx]; pipe_addr = op_addr[idx]; pipe_wdata = 32'h77;
            #1;
            checks++; if (pipe_stall !== (c == 5)) begin errors++; $display("FAIL force_stall c%0d got %b exp %b", c, pipe_stall, c == 5); end
            checks++; if (prev_stall && pipe_stall) begin errors++; $display("FAIL force_b2b c%0d got 1 exp 0", c); end
            if (c == 5) begin
                checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h010) begin errors++; $display("FAIL force_port got wr=%b rd=%b a=%h exp 0 1 010", mem_wr, mem_rd, mem_addr); end
            end
            if (c == 6) begin
                checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL force_rdata got v=%b d=%h exp 1 deadbeef", dbg_rvalid, dbg_rdata); end
            end
            if (dbg_ready && first_ready == 0) first_ready = c;
            prev_stall = pipe_stall;
            cyc();
            if (first_ready != 0) dbg_valid = 0;
            if (!prev_stall && idx < 5) idx++;
        end
        idle();
        checks++; if (first_ready != 5) begin errors++; $display("FAIL force_accept_cycle got %0d exp 5", first_ready); end
        checks++; if (wr30_cnt != 1 || mem[12] !== 32'h77) begin errors++; $display("FAIL force_once got n=%0d d=%h exp 1 77", wr30_cnt, mem[12]); end
    endtask

    task automatic test_reset_force();
        pipe_rd = 1; pipe_addr = 9'h000;
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h010;
        for (int c = 0; c < 4; c++) cyc();
        checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL rstf_enter got %b exp 1", pipe_stall); end
        reset = 1;
        cyc();
        reset = 0; dbg_valid = 0; pipe_addr = 9'h010;
        #1;
        checks++; if (pipe_stall !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rstf_state got s=%b v=%b exp 0 0", pipe_stall, dbg_rvalid); end
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 9'h010 || pipe_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rstf_pass got rd=%b a=%h d=%h exp 1 010 deadbeef", mem_rd, mem_addr, pipe_rdata); end
        cyc();
        idle();
    endtask
`else
    task automatic test_no_starve();
        int n_stall = 0;
        int n_ready = 0;
        pipe_rd = 1; pipe_addr = 9'h000;
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h010;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (pipe_stall) n_stall++;
            if (dbg_ready) n_ready++;
            cyc();
        end
        checks++; if (n_stall != 0) begin errors++; $display("FAIL nostarve_stall got %0d exp 0", n_stall); end
        checks++; if (n_ready != 0) begin errors++; $display("FAIL nostarve_ready got %0d exp 0", n_ready); end
        pipe_rd = 0;
        #1;
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL nostarve_release got %b exp 1", dbg_ready); end
        cyc();
        dbg_valid = 0;
        checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL nostarve_rdata got v=%b d=%h exp 1 deadbeef", dbg_rvalid, dbg_rdata); end
        idle();
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_dbg_write_read();
        test_priority();
`ifdef DMEM_ARB_STARVE_EN
        test_force();
        test_reset_force();
`else
        test_no_starve();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
